// File: rtl/mm_pkg.sv
// Shared types and constants for the main-memory responder.
package mm_pkg;

    typedef enum logic [0:0] {
        INIT  = 1'b0,
        READY = 1'b1
    } mm_state_t;

    localparam int MM_ADDR_WIDTH = 10;
    localparam int MM_DEPTH      = 1024;
    localparam int MM_STAT_WIDTH = 16;

    function automatic logic [MM_STAT_WIDTH-1:0] sat_inc16(input logic [MM_STAT_WIDTH-1:0] v);
        if (v == 16'hFFFF) begin
            return v;
        end else begin
            return v + 16'd1;
        end
    endfunction

endpackage

// File: rtl/mm_read_pipe.sv
// Valid/data delay line between the array read port and MM_read_word.
// Stage 0 is the incoming request; stages 1..read_latency-1 are registered.
module mm_read_pipe #(
    parameter int n            = 32,
    parameter int read_latency = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_valid,
    input  logic [n-1:0] i_data,
    output logic [n-1:0] o_data
);

    logic [read_latency-1:0] w_vld;
    logic [n-1:0]            w_data [read_latency];
    logic [n-1:0]            r_out;

    assign w_vld[0]  = i_valid;
    assign w_data[0] = i_data;

    for (genvar s = 1; s < read_latency; s++) begin : g_stage
        logic         r_vld;
        logic [n-1:0] r_data;

        // One delay stage; valid bits are flushed by reset.
        always_ff @(posedge clk) begin
            if (reset) begin
                r_vld  <= 1'b0;
                r_data <= '0;
            end else begin
                r_vld  <= w_vld[s-1];
                r_data <= w_data[s-1];
            end
        end

        assign w_vld[s]  = r_vld;
        assign w_data[s] = r_data;
    end

    // Output register holds the last delivered word between reads.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out <= '0;
        end else if (w_vld[read_latency-1]) begin
            r_out <= w_data[read_latency-1];
        end else begin
            r_out <= r_out;
        end
    end

    assign o_data = r_out;

endmodule

// File: rtl/main_memory.sv
// Word-addressed main memory behind the L2 MM_* interface, cleared after reset.
// Optional statistics counters are enabled by defining MAIN_MEMORY_STATS_EN.
module main_memory
    import mm_pkg::*;
#(
    parameter int n            = 32,
    parameter int addr_width   = MM_ADDR_WIDTH,
    parameter int read_latency = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [addr_width-1:0] MM_word_address,
    input  logic [n-1:0]          MM_write_word,
    input  logic                  MM_read_request,
    input  logic                  MM_write_request,
    output logic [n-1:0]          MM_read_word,
    output logic                  MM_ready,
    output logic [31:0]           MM_statistics
);

    localparam int DEPTH = 2 ** addr_width;

    logic [n-1:0]          r_mem [DEPTH];
    mm_state_t             r_state;
    logic [addr_width-1:0] r_clear_addr;
    logic                  r_ready;

    logic                  w_rd_acc;
    logic                  w_wr_acc;
    logic                  w_mem_we;
    logic [addr_width-1:0] w_mem_addr;
    logic [n-1:0]          w_mem_wdata;

    assign w_rd_acc = (r_state == READY) && MM_read_request;
    assign w_wr_acc = (r_state == READY) && MM_write_request;

    // Single array write port shared by the clear sweep and host writes.
    always_comb begin
        w_mem_we    = 1'b0;
        w_mem_addr  = MM_word_address;
        w_mem_wdata = MM_write_word;
        if (r_state == INIT) begin
            w_mem_we    = 1'b1;
            w_mem_addr  = r_clear_addr;
            w_mem_wdata = '0;
        end else begin
            w_mem_we    = w_wr_acc;
            w_mem_addr  = MM_word_address;
            w_mem_wdata = MM_write_word;
        end
    end

    // Array storage; contents are initialised by the sweep, not by reset.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_wdata;
        end
    end

    // Clear FSM: sweep every address once, then serve requests.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= INIT;
            r_clear_addr <= '0;
            r_ready      <= 1'b0;
        end else begin
            case (r_state)
                INIT: begin
                    r_clear_addr <= r_clear_addr + 1'b1;
                    if (r_clear_addr == {addr_width{1'b1}}) begin
                        r_state <= READY;
                        r_ready <= 1'b1;
                    end else begin
                        r_state <= INIT;
                        r_ready <= 1'b0;
                    end
                end
                READY: begin
                    r_state <= READY;
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state      <= INIT;
                    r_clear_addr <= '0;
                    r_ready      <= 1'b0;
                end
            endcase
        end
    end

    // The combinational array read sees pre-write content on a same-edge write.
    mm_read_pipe #(
        .n            (n),
        .read_latency (read_latency)
    ) u_read_pipe (
        .clk     (clk),
        .reset   (reset),
        .i_valid (w_rd_acc),
        .i_data  (r_mem[MM_word_address]),
        .o_data  (MM_read_word)
    );

    assign MM_ready = r_ready;

`ifdef MAIN_MEMORY_STATS_EN
    logic [MM_STAT_WIDTH-1:0] r_rd_cnt;
    logic [MM_STAT_WIDTH-1:0] r_wr_cnt;

    // Saturating accepted-request counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_cnt <= '0;
            r_wr_cnt <= '0;
        end else begin
            r_rd_cnt <= w_rd_acc ? sat_inc16(r_rd_cnt) : r_rd_cnt;
            r_wr_cnt <= w_wr_acc ? sat_inc16(r_wr_cnt) : r_wr_cnt;
        end
    end

    assign MM_statistics = {r_rd_cnt, r_wr_cnt};
`else
    assign MM_statistics = 32'd0;
`endif

endmodule
